// File: rtl/lfsr_stream_crypt.sv
// lfsr_stream_crypt
// Byte-stream LFSR cipher coprocessor. A Start/Ack job either encrypts a
// fixed-length frame (space preamble, message, trailing spaces, each XORed
// with a programmable-tap LFSR, parity in the MSB) or decrypts one. On decrypt
// it checks parity and strips the leading decoded spaces. It can also recover
// the seed from the first cipher byte.
// Ports:
//   Clk, Reset          clock, asynchronous active-high reset
//   Start / Ack         job start request / job complete (held until next Start)
//   mode                00 encrypt, 01/11 decrypt with seed, 10 decrypt with recovery
//   pre_len, msg_len    preamble and message lengths (encrypt only)
//   taps, seed          LFSR feedback mask and start state
//   in_valid/in_ready/in_data     input byte stream
//   out_valid/out_ready/out_data  output byte stream (single register stage)
//   out_len             bytes emitted in the current or last job
//   parity_errs         saturating decrypt parity-error count
//   busy                job running
module lfsr_stream_crypt #(
    parameter int LFSR_W    = 7,
    parameter int FRAME_LEN = 64,
    parameter int PRE_MIN   = 10,
    parameter int PRE_MAX   = 15
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Start,
    output logic              Ack,
    input  logic [1:0]        mode,
    input  logic [7:0]        pre_len,
    input  logic [7:0]        msg_len,
    input  logic [LFSR_W-1:0] taps,
    input  logic [LFSR_W-1:0] seed,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [LFSR_W:0]   in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [LFSR_W:0]   out_data,
    output logic [7:0]        out_len,
    output logic [7:0]        parity_errs,
    output logic              busy
);

    localparam int SW = $clog2(FRAME_LEN + 1);
    localparam logic [8:0]        FRAME_L9 = 9'(FRAME_LEN);
    localparam logic [8:0]        PRE_MIN9 = 9'(PRE_MIN);
    localparam logic [8:0]        PRE_MAX9 = 9'(PRE_MAX);
    localparam logic [LFSR_W-1:0] SPACE    = LFSR_W'(32'h20);
    localparam logic [LFSR_W-1:0] ONE      = LFSR_W'(32'h1);

    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_DONE = 2'd2} state_t;

    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s,
                                                    input logic [LFSR_W-1:0] t);
        return {s[LFSR_W-2:0], ^(s & t)};
    endfunction

    function automatic logic parity(input logic [LFSR_W-1:0] v);
        return ^v;
    endfunction

    state_t            state_r, state_nx_s;
    logic [LFSR_W-1:0] lfsr_r, taps_r, cur_s, plain_s, ciph_s;
    logic [SW-1:0]     slot_r;
    logic [1:0]        mode_r;
    logic [8:0]        pre_r, msg_end_r, pre_clamp_s, room_s, msg_clamp_s, slot9_s;
    logic              strip_r, out_valid_r, ack_r, busy_r;
    logic [LFSR_W:0]   out_data_r, res_s;
    logic [7:0]        out_len_r, perr_r;
    logic              start_s, enc_s, slot_live_s, need_in_s, room_out_s, fire_s;
    logic              emit_s, perr_hit_s;

    // Job control: start acceptance, length clamping and slot handshake.
    always_comb begin
        start_s = Start && (state_r != ST_RUN);
        if ({1'b0, pre_len} < PRE_MIN9) begin
            pre_clamp_s = PRE_MIN9;
        end else if ({1'b0, pre_len} > PRE_MAX9) begin
            pre_clamp_s = PRE_MAX9;
        end else begin
            pre_clamp_s = {1'b0, pre_len};
        end
        room_s      = FRAME_L9 - pre_clamp_s;
        msg_clamp_s = ({1'b0, msg_len} > room_s) ? room_s : {1'b0, msg_len};
        slot9_s     = 9'(slot_r);
        enc_s       = (mode_r == 2'b00);
        slot_live_s = (slot9_s < FRAME_L9);
        // Encrypt pads need no input; every decrypt slot consumes one byte.
        need_in_s   = enc_s ? ((slot9_s >= pre_r) && (slot9_s < msg_end_r)) : 1'b1;
        room_out_s  = !out_valid_r || out_ready;
        fire_s      = (state_r == ST_RUN) && slot_live_s && room_out_s &&
                      (!need_in_s || in_valid);
    end

    // Slot datapath: LFSR state in use, cipher/plain value, strip and parity.
    always_comb begin
        // Seed recovery: slot 0 state is chosen so that the byte decodes to a space.
        if ((mode_r == 2'b10) && (slot_r == SW'(0))) begin
            cur_s = in_data[LFSR_W-1:0] ^ SPACE;
        end else begin
            cur_s = lfsr_r;
        end
        plain_s    = SPACE;
        ciph_s     = {LFSR_W{1'b0}};
        res_s      = {(LFSR_W+1){1'b0}};
        emit_s     = 1'b1;
        perr_hit_s = 1'b0;
        if (enc_s) begin
            plain_s = need_in_s ? in_data[LFSR_W-1:0] : SPACE;
            ciph_s  = plain_s ^ cur_s;
            res_s   = {parity(ciph_s), ciph_s};
        end else begin
            ciph_s     = in_data[LFSR_W-1:0];
            plain_s    = ciph_s ^ cur_s;
            res_s      = {1'b0, plain_s};
            emit_s     = !(strip_r && (plain_s == SPACE));
            perr_hit_s = (in_data[LFSR_W] != parity(ciph_s));
        end
    end

    // Next-state logic; DONE is entered on the edge that drains the last byte.
    always_comb begin
        case (state_r)
            ST_IDLE: state_nx_s = start_s ? ST_RUN : ST_IDLE;
            ST_RUN:  state_nx_s = (!slot_live_s && room_out_s) ? ST_DONE : ST_RUN;
            ST_DONE: state_nx_s = start_s ? ST_RUN : ST_DONE;
            default: state_nx_s = ST_IDLE;
        endcase
    end

    // State register with registered Ack and busy.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_r <= ST_IDLE;
            ack_r   <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_nx_s;
            ack_r   <= (state_nx_s == ST_DONE);
            busy_r  <= (state_nx_s == ST_RUN);
        end
    end

    // Job configuration latched when a Start is accepted.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            mode_r    <= 2'b00;
            taps_r    <= {LFSR_W{1'b0}};
            pre_r     <= 9'd0;
            msg_end_r <= 9'd0;
        end else if (start_s) begin
            mode_r    <= mode;
            taps_r    <= taps;
            pre_r     <= pre_clamp_s;
            msg_end_r <= pre_clamp_s + msg_clamp_s;
        end else begin
            mode_r    <= mode_r;
            taps_r    <= taps_r;
            pre_r     <= pre_r;
            msg_end_r <= msg_end_r;
        end
    end

    // LFSR, slot counter and preamble-strip flag advance once per processed slot.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            lfsr_r  <= ONE;
            slot_r  <= SW'(0);
            strip_r <= 1'b1;
        end else if (start_s) begin
            lfsr_r  <= (seed == {LFSR_W{1'b0}}) ? ONE : seed;
            slot_r  <= SW'(0);
            strip_r <= 1'b1;
        end else if (fire_s) begin
            lfsr_r  <= lfsr_next(cur_s, taps_r);
            slot_r  <= slot_r + SW'(1);
            strip_r <= strip_r && !emit_s;
        end else begin
            lfsr_r  <= lfsr_r;
            slot_r  <= slot_r;
            strip_r <= strip_r;
        end
    end

    // Single-stage output register; holds while stalled.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            out_valid_r <= 1'b0;
            out_data_r  <= {(LFSR_W+1){1'b0}};
        end else if (fire_s && emit_s) begin
            out_valid_r <= 1'b1;
            out_data_r  <= res_s;
        end else if (out_ready) begin
            out_valid_r <= 1'b0;
            out_data_r  <= out_data_r;
        end else begin
            out_valid_r <= out_valid_r;
            out_data_r  <= out_data_r;
        end
    end

    // Emitted-byte and saturating parity-error counters.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            out_len_r <= 8'd0;
            perr_r    <= 8'd0;
        end else if (start_s) begin
            out_len_r <= 8'd0;
            perr_r    <= 8'd0;
        end else if (fire_s) begin
            out_len_r <= emit_s ? (out_len_r + 8'd1) : out_len_r;
            perr_r    <= (perr_hit_s && (perr_r != 8'hFF)) ? (perr_r + 8'd1) : perr_r;
        end else begin
            out_len_r <= out_len_r;
            perr_r    <= perr_r;
        end
    end

    assign in_ready    = (state_r == ST_RUN) && slot_live_s && room_out_s && need_in_s;
    assign out_valid   = out_valid_r;
    assign out_data    = out_data_r;
    assign out_len     = out_len_r;
    assign parity_errs = perr_r;
    assign Ack         = ack_r;
    assign busy        = busy_r;

endmodule

// File: tb/tb_lfsr_stream_crypt.sv
// Scoreboard bench for lfsr_stream_crypt: stimulus pushes expected bytes into
// exp_q, a negedge monitor pops and compares every output handshake.
module tb_lfsr_stream_crypt;
    localparam int FL = 64;

    logic       Clk = 1'b0;
    logic       Reset, Start, Ack, in_valid, in_ready, out_valid, out_ready, busy;
    logic [1:0] mode;
    logic [7:0] pre_len, msg_len, in_data, out_data, out_len, parity_errs;
    logic [6:0] taps, seed;

    lfsr_stream_crypt dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Ack(Ack), .mode(mode),
        .pre_len(pre_len), .msg_len(msg_len), .taps(taps), .seed(seed),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_len(out_len), .parity_errs(parity_errs), .busy(busy)
    );

    always #5 Clk = ~Clk;

    int         n_checks = 0;
    int         n_fail   = 0;
    int         n_acc    = 0;
    int         acc_base = 0;
    int         first_acc = -1;
    bit         bp_mode  = 1'b0;
    bit         gap_mode = 1'b0;
    logic [7:0] exp_q[$];
    logic [7:0] in_q[$];
    logic [7:0] cap_q[$];
    logic [7:0] cq[$];
    logic [7:0] pt[0:63];
    string      watson = "Mr. Watson, come here. I want to see you.";

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Input/backpressure driver, updated just after each rising edge.
    initial begin
        in_valid  = 1'b0;
        in_data   = 8'h00;
        out_ready = 1'b1;
        forever begin
            @(posedge Clk);
            #1;
            out_ready = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
            if ((n_acc - acc_base) < in_q.size() && !(gap_mode && $urandom_range(0, 2) == 0)) begin
                in_valid = 1'b1;
                in_data  = in_q[n_acc - acc_base];
            end else begin
                in_valid = 1'b0;
                in_data  = 8'h00;
            end
        end
    end

    // Monitor: handshakes, scoreboard pops, stall stability and Ack timing.
    initial begin
        bit         hold_v, ack_pend;
        logic [7:0] hold_d;
        hold_v   = 1'b0;
        ack_pend = 1'b0;
        hold_d   = 8'h00;
        forever begin
            @(negedge Clk);
            if (Reset) begin
                hold_v   = 1'b0;
                ack_pend = 1'b0;
            end else begin
                if (ack_pend) begin
                    check("ack_after_last", Ack, 1);
                    ack_pend = 1'b0;
                end
                if (hold_v) begin
                    check("stall_valid", out_valid, 1);
                    check("stall_data", out_data, hold_d);
                end
                hold_v = out_valid && !out_ready;
                hold_d = out_data;
                if (in_valid && in_ready) begin
                    if (n_acc == acc_base) first_acc = int'(out_len);
                    n_acc++;
                end
                if (out_valid && out_ready) begin
                    cap_q.push_back(out_data);
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL extra_out: got 0x%0h expected no byte", out_data);
                    end else begin
                        check("out_byte", out_data, exp_q.pop_front());
                        if (exp_q.size() == 0) ack_pend = 1'b1;
                    end
                end
            end
        end
    end

    task automatic load_str(input string s);
        for (int i = 0; i < 64; i++) pt[i] = (i < s.len()) ? s[i] : 8'h00;
    endtask

    task automatic load_alpha();
        for (int i = 0; i < 64; i++) pt[i] = 8'h41 + 8'(i % 26);
    endtask

    // Feed plaintext with MSB set so encrypt must ignore it.
    task automatic feed_pt(input int n);
        in_q.delete();
        for (int i = 0; i < n; i++) in_q.push_back({1'b1, pt[i][6:0]});
    endtask

    // Reference encrypt frame with already-clamped lengths.
    task automatic push_enc(input int pc, input int mc, input logic [6:0] t, input logic [6:0] s0);
        logic [6:0] s, p, c;
        s = (s0 == 7'd0) ? 7'd1 : s0;
        for (int i = 0; i < FL; i++) begin
            p = (i >= pc && i < pc + mc) ? pt[i - pc][6:0] : 7'h20;
            c = p ^ s;
            exp_q.push_back({^c, c});
            s = {s[5:0], ^(s & t)};
        end
    endtask

    // Decrypted frame after preamble strip: message then spaces to 54 bytes.
    task automatic push_plain(input int n);
        for (int i = 0; i < 54; i++) exp_q.push_back((i < n) ? {1'b0, pt[i][6:0]} : 8'h20);
    endtask

    task automatic start_job(input logic [1:0] m, input logic [7:0] pl, input logic [7:0] ml,
                             input logic [6:0] t, input logic [6:0] s);
        @(posedge Clk);
        #1;
        acc_base = n_acc;
        cap_q.delete();
        mode = m; pre_len = pl; msg_len = ml; taps = t; seed = s;
        Start = 1'b1;
        @(posedge Clk);
        #1;
        Start = 1'b0;
    endtask

    task automatic wait_done(input string nm, input int cons, input int len, input int perr);
        for (int i = 0; i < 3000; i++) begin
            @(negedge Clk);
            if (Ack === 1'b1) break;
        end
        check({nm, "_ack"}, Ack, 1);
        check({nm, "_left"}, exp_q.size(), 0);
        check({nm, "_consumed"}, n_acc - acc_base, cons);
        check({nm, "_out_len"}, out_len, len);
        check({nm, "_perr"}, parity_errs, perr);
        check({nm, "_busy"}, busy, 0);
        exp_q.delete();
    endtask

    initial begin
        logic [6:0] rt, rs;
        Reset = 1'b1; Start = 1'b0; mode = 2'b00; pre_len = 8'd0; msg_len = 8'd0;
        taps = 7'd0; seed = 7'd0;
        #12;
        check("rst_ack", Ack, 0);
        check("rst_busy", busy, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_len", out_len, 0);
        @(posedge Clk);
        #3;
        Reset = 1'b0;

        // Encrypt all spaces: first six bytes hand-computed.
        in_q.delete();
        push_enc(10, 0, 7'h60, 7'h01);
        exp_q[0] = 8'h21; exp_q[1] = 8'h22; exp_q[2] = 8'h24;
        exp_q[3] = 8'h28; exp_q[4] = 8'h30; exp_q[5] = 8'h00;
        start_job(2'b00, 8'd10, 8'd0, 7'h60, 7'h01);
        wait_done("spaces", 0, 64, 0);

        // Clamping of pre_len and msg_len.
        load_alpha();
        feed_pt(60);
        push_enc(10, 20, 7'h44, 7'h2B);
        start_job(2'b00, 8'd3, 8'd20, 7'h44, 7'h2B);
        wait_done("clamp_lo", 20, 64, 0);
        check("clamp_lo_first", first_acc, 10);
        feed_pt(60);
        push_enc(15, 20, 7'h44, 7'h2B);
        start_job(2'b00, 8'd40, 8'd20, 7'h44, 7'h2B);
        wait_done("clamp_hi", 20, 64, 0);
        check("clamp_hi_first", first_acc, 15);
        feed_pt(60);
        push_enc(10, 54, 7'h60, 7'h00);
        start_job(2'b00, 8'd10, 8'd60, 7'h60, 7'h00);
        wait_done("clamp_msg", 54, 64, 0);

        // Round trip with random taps and seed.
        load_str(watson);
        rt = 7'($urandom_range(1, 127));
        rs = 7'($urandom_range(0, 127));
        feed_pt(41);
        push_enc(10, 41, rt, rs);
        start_job(2'b00, 8'd10, 8'd41, rt, rs);
        wait_done("rt_enc", 41, 64, 0);
        in_q = cap_q;
        push_plain(41);
        start_job(2'b01, 8'd0, 8'd0, rt, rs);
        wait_done("rt_dec", 64, 54, 0);

        // Seed recovery and parity errors.
        feed_pt(41);
        push_enc(10, 41, 7'h60, 7'h01);
        start_job(2'b00, 8'd10, 8'd41, 7'h60, 7'h01);
        wait_done("sr_enc", 41, 64, 0);
        check("sr_byte0", cap_q[0], 8'h21);
        cq = cap_q;
        in_q = cq;
        push_plain(41);
        start_job(2'b01, 8'd0, 8'd0, 7'h60, 7'h01);
        wait_done("sr_mode01", 64, 54, 0);
        in_q = cq;
        push_plain(41);
        start_job(2'b10, 8'd0, 8'd0, 7'h60, 7'h55);
        wait_done("sr_mode10", 64, 54, 0);
        in_q = cq;
        push_plain(41);
        start_job(2'b11, 8'd0, 8'd0, 7'h60, 7'h01);
        wait_done("sr_mode11", 64, 54, 0);
        in_q = cq;
        in_q[20] = in_q[20] ^ 8'h80;
        in_q[30] = in_q[30] ^ 8'h80;
        push_plain(41);
        start_job(2'b10, 8'd0, 8'd0, 7'h60, 7'h55);
        wait_done("sr_perr", 64, 54, 2);

        // Backpressure and input gaps.
        bp_mode = 1'b1; gap_mode = 1'b1;
        feed_pt(41);
        push_enc(10, 41, 7'h60, 7'h01);
        start_job(2'b00, 8'd10, 8'd41, 7'h60, 7'h01);
        wait_done("bp_enc", 41, 64, 0);
        in_q = cq;
        push_plain(41);
        start_job(2'b01, 8'd0, 8'd0, 7'h60, 7'h01);
        wait_done("bp_dec", 64, 54, 0);
        bp_mode = 1'b0; gap_mode = 1'b0;

        // Asynchronous reset mid-job.
        load_alpha();
        feed_pt(30);
        push_enc(10, 30, 7'h60, 7'h01);
        start_job(2'b00, 8'd10, 8'd30, 7'h60, 7'h01);
        for (int i = 0; i < 500; i++) begin
            @(negedge Clk);
            if (out_len >= 8'd30) break;
        end
        check("pre_rst_len", out_len, 30);
        #2;
        Reset = 1'b1;
        #1;
        check("arst_ack", Ack, 0);
        check("arst_busy", busy, 0);
        check("arst_out_valid", out_valid, 0);
        check("arst_in_ready", in_ready, 0);
        check("arst_out_len", out_len, 0);
        check("arst_perr", parity_errs, 0);
        check("arst_out_data", out_data, 0);
        exp_q.delete();
        in_q.delete();
        @(posedge Clk);
        @(posedge Clk);
        #3;
        acc_base = n_acc;
        Reset = 1'b0;

        // Full job after reset, with a Start pulse during RUN that must be ignored.
        load_str(watson);
        feed_pt(41);
        push_enc(10, 41, 7'h60, 7'h01);
        start_job(2'b00, 8'd10, 8'd41, 7'h60, 7'h01);
        for (int i = 0; i < 500; i++) begin
            @(negedge Clk);
            if (out_len >= 8'd20) break;
        end
        @(posedge Clk);
        #1;
        mode = 2'b01; pre_len = 8'd12; msg_len = 8'd5; taps = 7'h11; seed = 7'h33;
        Start = 1'b1;
        @(posedge Clk);
        #1;
        Start = 1'b0;
        wait_done("restart", 41, 64, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/lfsr_stream_crypt.md
# lfsr_stream_crypt

Parametrised hardware LFSR stream-cipher engine that takes over the message encrypt/decrypt job from the processor program. It sits beside `TopLevel` as a byte-stream coprocessor. It is started with the same Start/Ack handshake and produces fixed-length frames, each made of space padding, the message, then trailing spaces, XORed with a programmable-tap LFSR and carrying a parity MSB. Beyond the program-1 behaviour it adds decryption, recovery of the seed from the frame's first byte, stripping of the preamble on decrypt, and parity-error counting.

## Interface
- `LFSR_W`, default 7: LFSR and payload width. Data byte width is `LFSR_W+1`, with parity in the MSB. Must be ≥ 6.
- `FRAME_LEN`, default 64: output slots per encrypt job and input bytes per decrypt job.
- `PRE_MIN`, default 10: lower clamp for `pre_len`.
- `PRE_MAX`, default 15: upper clamp for `pre_len`.

Ports:
- `Clk`  in  1  single clock; all logic is rising-edge.
- `Reset`  in  1  asynchronous, active-high; clears everything.
- `Start`  in  1  starts a job when sampled high in IDLE or DONE.
- `Ack`  out  1  job complete; held high until the next accepted Start.
- `mode`  in  2  00 encrypt, 01 decrypt with given seed, 10 decrypt with seed recovery, 11 treated as 01.
- `pre_len`  in  8  preamble space count (encrypt only).
- `msg_len`  in  8  plaintext character count (encrypt only).
- `taps`  in  LFSR_W  feedback tap mask.
- `seed`  in  LFSR_W  LFSR start state; 0 is replaced by 1.
- `in_valid` / `in_ready` / `in_data[LFSR_W:0]`: input byte stream.
- `out_valid` / `out_ready` / `out_data[LFSR_W:0]`: output byte stream.
- `out_len`  out  8  bytes emitted in the current or last job.
- `parity_errs`  out  8  decrypt parity mismatches, saturating at 255.
- `busy`  out  1  high in RUN.

## Operation
- **States:** IDLE, RUN, DONE.
- **IDLE/DONE + Start:** go to RUN, and on that edge:
  - latch mode, taps and seed (seed 0 becomes 1);
  - latch `pre_len` clamped to [PRE_MIN, PRE_MAX];
  - latch `msg_len` clamped to FRAME_LEN − clamped `pre_len`;
  - clear `slot`, `out_len`, `parity_errs`;
  - drop `Ack`.
- **Start in RUN:** ignored.
- **LFSR step:** `next = {s[LFSR_W-2:0], ^(s & taps)}`. Slot i uses state s_i. The LFSR advances once per processed slot.
- **Encrypt:**
  - Slot i's plain value `p` is:
    - 0x20 for i < pre_len, with no input consumed;
    - the next input byte's `[LFSR_W-1:0]` for pre_len ≤ i < pre_len+msg_len;
    - 0x20 otherwise.
  - `c = p ^ s_i`; `out_data = {^c, c}`.
  - Every slot is emitted, so `out_len` ends at FRAME_LEN.
- **Decrypt:**
  - Each slot consumes one input byte `b`.
  - A parity error is `b[LFSR_W] != ^b[LFSR_W-1:0]`; it increments `parity_errs`.
  - `p = b[LFSR_W-1:0] ^ s_i`; output is `{1'b0, p}`.
- **Seed recovery (mode 10):** s_0 = b0[LFSR_W-1:0] ^ 0x20, so slot 0 decodes to a space. The latched `seed` is unused.
- **Preamble strip (decrypt):** leading decoded 0x20 bytes are not emitted, but the LFSR and `slot` still advance. From the first non-space byte onward, every byte is emitted, including trailing spaces.
- **Completion:** RUN→DONE when `slot` reaches FRAME_LEN and the output register is empty. Ack=1 in DONE.
- **Reset at any time:** IDLE, LFSR = 1, `Ack`/`busy`/`out_valid`/`in_ready`/`out_len`/`parity_errs` = 0, `out_data` = 0.

## Timing
- The output register is a single stage.
- A slot is processed on an edge where RUN holds, `slot` < FRAME_LEN, `(!out_valid || out_ready)` holds, and, if the slot needs input, `in_valid` is high.
- `in_ready` is combinational: RUN, slot needs input, slot < FRAME_LEN, and `(!out_valid || out_ready)`.
- Latency: a byte accepted at edge k is on `out_data` with `out_valid` high after edge k.
- Throughput is 1 byte/cycle with out_ready tied high. Encrypt pad slots need no input.
- `out_data` and `out_valid` are stable while `out_valid && !out_ready`.
- A stripped preamble slot processes with `out_valid` unchanged.
- `Ack` rises on the edge after the final output handshake (the edge that empties the register).
- `Start` in DONE: `Ack` falls and RUN begins on the same edge.
- `busy` is registered and equals state==RUN.

## Test plan
- **Encrypt spaces:** taps=0x60, seed=0x01, pre_len=10, msg_len=0, out_ready=1 → out_data 0x21, 0x22, 0x24, 0x28, 0x30, 0x00 for slots 0–5; 64 bytes total; `Ack` 1 cycle after the last byte.
- **Clamping:** pre_len=3 → the first input is accepted at slot 10. pre_len=40 → first input at slot 15. msg_len=60 with pre_len 10 → only 54 inputs consumed.
- **Round trip:** encrypt "Mr. Watson, come here. I want to see you." with random taps and seed, then decrypt in mode 01 with the same taps and seed → output equals the string plus trailing spaces; out_len = 64 − 10 = 54 (preamble stripped); parity_errs = 0.
- **Seed recovery:** mode 10, cipher byte 0 = 0x21, taps=0x60 → s_0 = 0x01 and the output matches the mode-01 decrypt. Flipping the MSB of two input bytes → parity_errs = 2.
- **Backpressure:** out_ready toggling randomly with in_valid gaps → no dropped or duplicated bytes, `out_data` held stable while stalled, and the same result as the unstalled run.
- **Reset and restart:** Reset asserted asynchronously at slot 30 → all outputs 0 immediately with no waiting for a clock edge. Then Start → a full correct job. Start pulsed during RUN → ignored, result unchanged.
